// File: rtl/rv32i_encoder_if.sv
// Request/response bus of the RV32I encoder: field-level requests in, tagged machine words out.
// The producer/consumer side (loader or bench) uses master; the encoder uses slave.
interface rv32i_encoder_if #(
  parameter int ADDR_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [6:0]        in_opcode;
  logic [2:0]        in_funct3;
  logic              in_alt;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [31:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_ins;
  logic [ADDR_W-1:0] out_addr;

  modport master (
    output in_valid, in_opcode, in_funct3, in_alt, in_rd, in_rs1, in_rs2, in_imm,
    input  in_ready,
    input  out_valid, out_ins, out_addr,
    output out_ready
  );

  modport slave (
    input  in_valid, in_opcode, in_funct3, in_alt, in_rd, in_rs1, in_rs2, in_imm,
    output in_ready,
    output out_valid, out_ins, out_addr,
    input  out_ready
  );
endinterface

// File: rtl/rv32i_encoder.sv
// RV32I field-to-machine-word encoder with one registered output stage and address tagging.
// Optional macro IMM_RANGE_CHECK_EN: out-of-range immediates become NOP and set err.
module rv32i_encoder #(
  parameter int                 ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
  parameter int                 CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              restart,
  rv32i_encoder_if.slave    bus,
  output logic              err,
  output logic [CNT_W-1:0]  word_count
);
  localparam logic [6:0]  OP_OPIMM  = 7'b0010011;
  localparam logic [6:0]  OP_OP     = 7'b0110011;
  localparam logic [6:0]  OP_LUI    = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  logic              r_out_valid;
  logic [31:0]       r_out_ins;
  logic [ADDR_W-1:0] r_out_addr;
  logic [ADDR_W-1:0] r_next_addr;
  logic              r_err;
  logic [CNT_W-1:0]  r_word_count;

  logic              w_accept;
  logic              w_handshake;
  logic              w_ill;
  logic [31:0]       w_ins;
  logic [6:0]        w_funct7;
  logic [6:0]        w_op;
  logic [2:0]        w_f3;
  logic [31:0]       w_imm;

  assign w_op  = bus.in_opcode;
  assign w_f3  = bus.in_funct3;
  assign w_imm = bus.in_imm;
  assign w_funct7 = bus.in_alt ? 7'b0100000 : 7'b0000000;

`ifdef IMM_RANGE_CHECK_EN
  logic w_i_bad;
  logic w_sh_bad;
  logic w_b_bad;
  logic w_j_bad;
  logic w_u_bad;
  assign w_i_bad  = ($signed(w_imm) < -32'sd2048) || ($signed(w_imm) > 32'sd2047);
  assign w_sh_bad = (w_imm > 32'd31);
  assign w_b_bad  = ($signed(w_imm) < -32'sd4096) || ($signed(w_imm) > 32'sd4094) || w_imm[0];
  assign w_j_bad  = ($signed(w_imm) < -32'sd1048576) || ($signed(w_imm) > 32'sd1048574) || w_imm[0];
  assign w_u_bad  = (w_imm[11:0] != 12'd0);
`endif

  always_comb begin
    w_ill = 1'b0;
    w_ins = NOP;
    case (w_op)
      OP_OPIMM: begin
        if (w_f3 == 3'b001 || w_f3 == 3'b101) begin
          w_ins = {w_funct7, w_imm[4:0], bus.in_rs1, w_f3, bus.in_rd, w_op};
          if (w_f3 == 3'b001 && bus.in_alt) w_ill = 1'b1;
`ifdef IMM_RANGE_CHECK_EN
          if (w_sh_bad) w_ill = 1'b1;
`endif
        end else begin
          w_ins = {w_imm[11:0], bus.in_rs1, w_f3, bus.in_rd, w_op};
`ifdef IMM_RANGE_CHECK_EN
          if (w_i_bad) w_ill = 1'b1;
`endif
        end
      end
      OP_OP: begin
        w_ins = {w_funct7, bus.in_rs2, bus.in_rs1, w_f3, bus.in_rd, w_op};
        if (bus.in_alt && w_f3 != 3'b000 && w_f3 != 3'b101) w_ill = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        w_ins = {w_imm[31:12], bus.in_rd, w_op};
`ifdef IMM_RANGE_CHECK_EN
        if (w_u_bad) w_ill = 1'b1;
`endif
      end
      OP_JAL: begin
        w_ins = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], bus.in_rd, w_op};
`ifdef IMM_RANGE_CHECK_EN
        if (w_j_bad) w_ill = 1'b1;
`endif
      end
      OP_JALR: begin
        // funct3 is not a free field for JALR; whatever the producer sent is ignored
        w_ins = {w_imm[11:0], bus.in_rs1, 3'b000, bus.in_rd, w_op};
`ifdef IMM_RANGE_CHECK_EN
        if (w_i_bad) w_ill = 1'b1;
`endif
      end
      OP_BRANCH: begin
        w_ins = {w_imm[12], w_imm[10:5], bus.in_rs2, bus.in_rs1, w_f3, w_imm[4:1], w_imm[11], w_op};
        if (w_f3 == 3'b010 || w_f3 == 3'b011) w_ill = 1'b1;
`ifdef IMM_RANGE_CHECK_EN
        if (w_b_bad) w_ill = 1'b1;
`endif
      end
      OP_STORE: begin
        w_ins = {w_imm[11:5], bus.in_rs2, bus.in_rs1, w_f3, w_imm[4:0], w_op};
        if (w_f3 > 3'b010) w_ill = 1'b1;
`ifdef IMM_RANGE_CHECK_EN
        if (w_i_bad) w_ill = 1'b1;
`endif
      end
      OP_LOAD: begin
        w_ins = {w_imm[11:0], bus.in_rs1, w_f3, bus.in_rd, w_op};
        if (w_f3 == 3'b011 || w_f3 == 3'b110 || w_f3 == 3'b111) w_ill = 1'b1;
`ifdef IMM_RANGE_CHECK_EN
        if (w_i_bad) w_ill = 1'b1;
`endif
      end
      default: w_ill = 1'b1;
    endcase
    if (w_ill) w_ins = NOP;
  end

  assign bus.in_ready = !r_out_valid || bus.out_ready;
  assign w_accept     = bus.in_valid && bus.in_ready;
  assign w_handshake  = r_out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_ins    <= '0;
      r_out_addr   <= BASE_ADDR;
      r_next_addr  <= BASE_ADDR;
      r_err        <= 1'b0;
      r_word_count <= '0;
    end else begin
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_ins   <= w_ins;
      end else if (w_handshake) begin
        r_out_valid <= 1'b0;
      end

      // restart re-bases the counter; a word accepted in the same cycle lands on BASE_ADDR
      if (restart) begin
        r_err        <= w_accept && w_ill;
        r_word_count <= '0;
        if (w_accept) begin
          r_out_addr  <= BASE_ADDR;
          r_next_addr <= BASE_ADDR + ADDR_W'(4);
        end else begin
          r_next_addr <= BASE_ADDR;
        end
      end else begin
        if (w_accept) begin
          r_out_addr  <= r_next_addr;
          r_next_addr <= r_next_addr + ADDR_W'(4);
          if (w_ill) r_err <= 1'b1;
        end
        if (w_handshake && r_word_count != {CNT_W{1'b1}})
          r_word_count <= r_word_count + CNT_W'(1);
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_ins   = r_out_ins;
  assign bus.out_addr  = r_out_addr;
  assign err           = r_err;
  assign word_count    = r_word_count;
endmodule

// File: doc/rv32i_encoder.md
Name: rv32i_encoder

Overview:
- Inverse of the core's RV32I instruction decoder. Takes field-level instruction requests (opcode, funct3, alt, rd, rs1, rs2, immediate) and produces 32-bit RV32I machine words.
- Each output word is tagged with a sequential instruction-memory address.
- Used by the boot/program loader and testbenches to build instruction-memory images.
- Valid/ready on input and output; one registered output stage.

Parameters:
- ADDR_W, 32, width of out_addr and the internal address counter.
- BASE_ADDR, 32'h0000_0000, address of the first word after reset or restart.
- CNT_W, 16, width of word_count.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- restart  in  1  re-base address counter; clears err and word_count
- in_valid  in  1  request valid
- in_ready  out  1  encoder can accept a request
- in_opcode  in  7  major opcode: OPIMM, OP, LUI, AUIPC, JAL, JALR, BRANCH, STORE, LOAD
- in_funct3  in  3  funct3 field
- in_alt  in  1  selects funct7=0100000 (SUB/SRA); 0 selects funct7=0
- in_rd  in  5  destination register
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2
- in_imm  in  32  immediate, byte offset, sign-extended by the producer
- out_valid  out  1  encoded word valid
- out_ready  in  1  consumer accepts the word
- out_ins  out  32  encoded machine word
- out_addr  out  ADDR_W  address assigned to out_ins
- err  out  1  sticky: an illegal request was encoded as NOP
- word_count  out  CNT_W  words accepted by the consumer, saturating

Behaviour:
- Reset (rst=1 at a clk edge): out_valid=0, out_ins=0, out_addr=BASE_ADDR, next_addr=BASE_ADDR, err=0, word_count=0. Reset in mid-stream drops any held word.
- in_ready = !out_valid || out_ready, combinational.
- Accept = in_valid && in_ready. On accept, the encoded word is registered next edge: latency 1 cycle, throughput 1 word/cycle.
- On accept: out_addr <= next_addr; next_addr += 4, wrapping modulo 2^ADDR_W.
- Output handshake (out_valid && out_ready): word_count += 1, saturates at all-ones. out_valid drops unless a new request is accepted the same cycle.
- While out_valid && !out_ready: out_ins and out_addr held stable; no accept.
- restart priority over accept: next_addr, err and word_count cleared. A word accepted in the same cycle takes BASE_ADDR and next_addr becomes BASE_ADDR+4. A held output word is not dropped.
- Encoding (op = in_opcode):
  - OPIMM: {imm[11:0],rs1,f3,rd,op}.
  - OPIMM shifts (f3=001/101): {funct7,imm[4:0],rs1,f3,rd,op}, funct7=alt?0100000:0. alt with f3=001 is illegal.
  - OP: {funct7,rs2,rs1,f3,rd,op}. alt is legal only with f3=000/101.
  - LUI/AUIPC: {imm[31:12],rd,op}.
  - JAL: {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
  - JALR: I-type with f3 forced to 000.
  - BRANCH: {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}. f3=010/011 is illegal.
  - STORE: {imm[11:5],rs2,rs1,f3,imm[4:0],op}. f3 above 010 is illegal.
  - LOAD: I-type. f3=011/110/111 is illegal.
- Illegal request, including any unlisted opcode: out_ins=32'h0000_0013 (NOP), err<=1, address still consumed.
- Without range checking, immediate bits outside the field are silently dropped; imm[0] is ignored for JAL/BRANCH.

Optional Feature:
- Macro: IMM_RANGE_CHECK_EN.
- Defined: a request is illegal (NOP, err set) if any of the following holds:
  - I/S immediate outside -2048..2047
  - shift amount above 31
  - BRANCH immediate outside -4096..4094 or odd
  - JAL immediate outside ±1 MiB or odd
  - LUI/AUIPC imm[11:0] nonzero
- Undefined: no range checks; truncation as above.

Test Plan:
- addi x1,x0,5 (op 0010011, f3 0, rd 1, imm 5), out_ready=1 -> out_ins=0x00500093, out_addr=0, next word out_addr=4.
- sub x3,x1,x2 (op 0110011, alt 1), then lui x5,0x12345000 -> 0x402081B3, then 0x123452B7, addresses 0 and 4.
- beq x1,x2,-4 and sw x2,8(x1) -> 0xFE208EE3 and 0x0020A423; jal x1,+8 -> 0x008000EF.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_ins/out_addr stable, word_count unchanged, second word follows on release.
- addi x1,x0,2048 -> with IMM_RANGE_CHECK_EN: 0x00000013 and err=1; without: 0x80000093 and err=0. Unknown opcode 0x7F -> NOP, err=1.
- After 3 words, restart together with a new accept -> new word out_addr=BASE_ADDR, err=0, word_count=0; rst during a held word -> out_valid=0 next cycle.
